// File: rtl/ov5640_capture_gen_if.sv
// Camera-side pixel bus into the capture block and the gated, assembled pixel bus out of it.
interface ov5640_capture_gen_if #(
  parameter int IN_W = 8
);
  logic              cam_vsync;
  logic              cam_href;
  logic [IN_W-1:0]   cam_data;
  logic              cmos_frame_vsync;
  logic              cmos_frame_href;
  logic              cmos_frame_valid;
  logic [2*IN_W-1:0] cmos_frame_data;
  logic [11:0]       pix_x;
  logic [11:0]       pix_y;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data, pix_x, pix_y
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data, pix_x, pix_y
  );
endinterface

// File: rtl/ov5640_capture_gen.sv
// OV5640 DVP capture: discards start-up frames, assembles RGB565/RAW pixels,
// tracks pixel coordinates and flags frames whose geometry does not match H_ACT x V_ACT.
module ov5640_capture_gen #(
  parameter int WAIT_FRAME = 10,
  parameter int IN_W       = 8,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480
) (
  input  logic                     cam_pclk,
  input  logic                     rst_n,
  ov5640_capture_gen_if.slave      cam,
  input  logic                     capture_en,
  input  logic [1:0]               pix_mode,
  input  logic                     err_clr,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt,
  output logic                     size_err
);

  typedef enum logic [1:0] {S_WAIT, S_ARMED, S_RUN} state_t;

  state_t            state;
  logic              vsync_d1, vsync_d2, vsync_d3;
  logic              href_d1, href_d2, href_d3;
  logic [IN_W-1:0]   data_d1, data_d2, byte_hold;
  logic [7:0]        wait_cnt;
  logic [1:0]        mode_q;
  logic              phase;
  logic [11:0]       px_cnt, x_cnt, y_cnt;
  logic              valid_q;
  logic [2*IN_W-1:0] data_q;

  logic pos_vsync, href_fall, run, raw_mode, pix_done, line_err, frame_err, frame_start;

  assign pos_vsync   = vsync_d2 & ~vsync_d3;
  assign href_fall   = ~href_d2 & href_d3;
  assign run         = (state == S_RUN);
  assign raw_mode    = (mode_q == 2'd2);
  assign pix_done    = run & href_d2 & (raw_mode | phase);
  assign line_err    = run & href_fall & ((px_cnt != 12'(H_ACT)) | (phase & ~raw_mode));
  assign frame_err   = run & pos_vsync & (y_cnt != 12'(V_ACT));
  assign frame_start = pos_vsync & (run | ((state == S_ARMED) & capture_en));

  // Everything downstream is gated to zero unless a frame is being captured.
  assign cam.cmos_frame_vsync = run & vsync_d2;
  assign cam.cmos_frame_href  = run & href_d2;
  assign cam.cmos_frame_valid = run & valid_q;
  assign cam.cmos_frame_data  = run ? data_q : '0;
  assign cam.pix_x            = run ? x_cnt : 12'd0;
  assign cam.pix_y            = y_cnt;
  assign frame_done           = run & pos_vsync;

  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      vsync_d1  <= 1'b0;
      vsync_d2  <= 1'b0;
      vsync_d3  <= 1'b0;
      href_d1   <= 1'b0;
      href_d2   <= 1'b0;
      href_d3   <= 1'b0;
      data_d1   <= '0;
      data_d2   <= '0;
      byte_hold <= '0;
      wait_cnt  <= 8'd0;
      mode_q    <= 2'd0;
      phase     <= 1'b0;
      px_cnt    <= 12'd0;
      x_cnt     <= 12'd0;
      y_cnt     <= 12'd0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      frame_cnt <= 16'd0;
      size_err  <= 1'b0;
    end else begin
      vsync_d1 <= cam.cam_vsync;
      vsync_d2 <= vsync_d1;
      vsync_d3 <= vsync_d2;
      href_d1  <= cam.cam_href;
      href_d2  <= href_d1;
      href_d3  <= href_d2;
      data_d1  <= cam.cam_data;
      data_d2  <= data_d1;
      valid_q  <= 1'b0;

      if (pos_vsync)
        mode_q <= pix_mode;

      // capture_en only matters at frame boundaries, so a frame is never cut short.
      case (state)
        S_WAIT: begin
          if (wait_cnt == 8'(WAIT_FRAME))
            state <= S_ARMED;
          else if (pos_vsync)
            wait_cnt <= wait_cnt + 8'd1;
        end
        S_ARMED: if (pos_vsync && capture_en) state <= S_RUN;
        S_RUN:   if (pos_vsync && !capture_en) state <= S_ARMED;
        default: state <= S_WAIT;
      endcase

      if (frame_start)
        y_cnt <= 12'd0;
      else if (run && href_fall && y_cnt != 12'hFFF)
        y_cnt <= y_cnt + 12'd1;

      if (run) begin
        phase <= href_d2 ? ~phase : 1'b0;

        if (href_fall || pos_vsync) begin
          x_cnt  <= 12'd0;
          px_cnt <= 12'd0;
        end else begin
          if (valid_q && x_cnt != 12'hFFF)
            x_cnt <= x_cnt + 12'd1;
          if (pix_done && px_cnt != 12'hFFF)
            px_cnt <= px_cnt + 12'd1;
        end

        if (href_d2 && !phase)
          byte_hold <= data_d2;

        if (pix_done) begin
          valid_q <= 1'b1;
          case (mode_q)
            2'd1:    data_q <= {data_d2, byte_hold};
            2'd2:    data_q <= {{IN_W{1'b0}}, data_d2};
            default: data_q <= {byte_hold, data_d2};
          endcase
        end
      end

      if (run && pos_vsync)
        frame_cnt <= frame_cnt + 16'd1;

      // A fresh geometry error outranks a simultaneous clear request.
      if (line_err || frame_err)
        size_err <= 1'b1;
      else if (err_clr)
        size_err <= 1'b0;
    end
  end

endmodule

// File: doc/ov5640_capture_gen.md
OV5640_CAPTURE_GEN -- requirements
Module: ov5640_capture_gen

Interface
REQ-001 Parameter WAIT_FRAME, default 10, frames discarded after reset before capture may start (range 0..255).
REQ-002 Parameter IN_W, default 8, camera data bus width; pixel output width is 2*IN_W.
REQ-003 Parameter H_ACT, default 640, expected valid pixels per line.
REQ-004 Parameter V_ACT, default 480, expected lines per frame.
REQ-005 cam_pclk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 cam_vsync  in  1  camera frame sync, active high.
REQ-008 cam_href  in  1  camera line valid, active high.
REQ-009 cam_data  in  IN_W  camera data.
REQ-010 capture_en  in  1  level; permits capture start/continuation.
REQ-011 pix_mode  in  2  0=RGB565 first-byte-high, 1=RGB565 byte-swapped, 2=RAW (1 byte/pixel, zero-extended), 3=reserved (treated as 0).
REQ-012 err_clr  in  1  one-cycle pulse clearing size_err.
REQ-013 cmos_frame_vsync  out  1  gated, delayed frame sync.
REQ-014 cmos_frame_href  out  1  gated, delayed line valid.
REQ-015 cmos_frame_valid  out  1  one-cycle pixel strobe.
REQ-016 cmos_frame_data  out  2*IN_W  assembled pixel.
REQ-017 pix_x  out  12  index of the pixel presented with cmos_frame_valid.
REQ-018 pix_y  out  12  current line index.
REQ-019 frame_done  out  1  one-cycle pulse at end of a captured frame.
REQ-020 frame_cnt  out  16  captured-frame count, wraps 0xFFFF->0.
REQ-021 size_err  out  1  sticky geometry/odd-byte error.

Function
REQ-022 cam_vsync and cam_href SHALL be registered twice; pos_vsync = rising edge seen on the second stage; href_fall likewise on the href second stage.
REQ-023 FSM states WAIT, ARMED, RUN; WAIT counts pos_vsync events, moving to ARMED when count reaches WAIT_FRAME (WAIT_FRAME=0: ARMED in first cycle after reset).
REQ-024 ARMED->RUN on pos_vsync with capture_en=1; RUN->ARMED on pos_vsync with capture_en=0 (current frame always completes).
REQ-025 Outside RUN, all cmos_frame_* outputs, frame_done and pix_x SHALL be 0; counters hold.
REQ-026 cmos_frame_vsync/href SHALL equal the second-stage synchronised cam_vsync/cam_href while in RUN.
REQ-027 pix_mode SHALL be sampled only at pos_vsync; mid-frame changes have no effect until next frame.
REQ-028 Byte phase toggles per cycle with cam_href=1, clears when cam_href=0; RGB modes emit a pixel on the second byte, RAW on every byte.
REQ-029 Mode 0 data = {byte0,byte1}; mode 1 = {byte1,byte0}; mode 2 = {IN_W zeros, byte}.
REQ-030 cmos_frame_data/valid SHALL be registered: valid high exactly 1 cycle, 2 cycles after the completing byte is sampled; data holds between strobes.
REQ-031 pix_x SHALL start at 0 per line and increment after each strobe; pix_y resets to 0 at pos_vsync and increments at each href_fall in RUN; both saturate at 4095.
REQ-032 At href_fall in RUN: pixel count != H_ACT, or a half pixel pending in RGB mode, SHALL set size_err; the half byte is discarded.
REQ-033 At pos_vsync in RUN: line count != V_ACT SHALL set size_err; frame_done pulses 1 cycle and frame_cnt increments.
REQ-034 err_clr coincident with a new error: error wins (size_err stays 1).
REQ-035 capture_en deassert/reassert within one frame SHALL not drop or duplicate frames.

Reset
REQ-036 With rst_n=0 at a clock edge: FSM=WAIT, all counters, sync stages, byte phase, frame_cnt, size_err and all outputs SHALL be 0.
REQ-037 Reset asserted mid-frame SHALL abort capture; WAIT_FRAME frames are again discarded after release.

Verification
REQ-038 WAIT_FRAME=2, capture_en=1, 3 frames 4x2 mode 0 -> no strobes in frames 1-2; frame 3 gives 8 strobes, frame_cnt=1 at next vsync.
REQ-039 Mode 0 bytes 0x12,0x34 -> data 0x1234; mode 1 -> 0x3412; mode 2 byte 0xAB -> 0x00AB, 2-cycle latency each.
REQ-040 Line of 7 bytes in mode 0 with H_ACT=4 -> 3 strobes, size_err=1; err_clr -> 0.
REQ-041 pix_mode changed 0->2 mid-line -> current frame stays RGB565, next frame RAW.
REQ-042 capture_en dropped mid-frame -> frame completes, frame_done pulses, next frame fully gated.
REQ-043 rst_n low mid-line then released -> all outputs 0, WAIT_FRAME frames re-skipped.
